// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32 pipeline control: branch resolution, PC redirect, flush/stall, branch counters
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ix_fire,
    input  logic [2:0]       ix_branch,
    input  logic             ix_zero,
    input  logic             ix_less,
    input  logic [31:0]      ix_pc,
    input  logic [31:0]      ix_imm,
    input  logic [31:0]      ix_busa,
    input  logic             ix_valid,
    input  logic [4:0]       ix_rd,
    input  logic             ix_memtoreg,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             redirect_ready,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ix,
    output logic             stall_id,
    output logic             busy,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    typedef enum logic [1:0] {S_RUN, S_REDIR, S_DRAIN} state_t;

    // Counter load value once IF accepts the redirect; DRAIN then lasts FLUSH_CYCLES cycles.
    localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               flush_ix_q, flush_ix_d;
    logic [CNT_W-1:0]   br_total_q, br_total_d;
    logic [CNT_W-1:0]   br_taken_q, br_taken_d;

    logic               resolved;
    logic               cond_taken;
    logic               taken;
    logic [31:0]        jalr_sum;
    logic [31:0]        target;
    logic               load_use;

    // Branch resolution: only a firing control-transfer in RUN counts; wrong-path fires are ignored.
    always_comb begin
        resolved   = ix_fire && (state_q == S_RUN) && (ix_branch != 3'b000);
        cond_taken = 1'b0;
        case (ix_branch)
            3'b001, 3'b010: cond_taken = 1'b1;
            3'b100:         cond_taken = ix_zero;
            3'b101:         cond_taken = ~ix_zero;
            3'b110, 3'b011: cond_taken = ix_less;
            3'b111:         cond_taken = ~ix_less;
            default:        cond_taken = 1'b0;
        endcase
        taken    = resolved && cond_taken;
        jalr_sum = ix_busa + ix_imm;
        target   = (ix_branch == 3'b010) ? {jalr_sum[31:1], 1'b0} : (ix_pc + ix_imm);
    end

    // Datapath next values: redirect target latch, IX flush pulse, wrapping perf counters.
    always_comb begin
        redirect_pc_d = taken ? target : redirect_pc_q;
        flush_ix_d    = taken;
        br_total_d    = br_total_q + CNT_W'(resolved);
        br_taken_d    = br_taken_q + CNT_W'(taken);
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_RUN;
            cnt_q         <= 4'd0;
            redirect_pc_q <= 32'd0;
            flush_ix_q    <= 1'b0;
            br_total_q    <= '0;
            br_taken_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_pc_q <= redirect_pc_d;
            flush_ix_q    <= flush_ix_d;
            br_total_q    <= br_total_d;
            br_taken_q    <= br_taken_d;
        end
    end

    // Next-state logic: RUN -> REDIR on taken, REDIR waits for IF, DRAIN counts down the flush window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (taken) begin
                    state_d = S_REDIR;
                end
            end
            S_REDIR: begin
                if (redirect_ready) begin
                    cnt_d   = DRAIN_INIT;
                    state_d = (DRAIN_INIT == 4'd0) ? S_RUN : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: flushes dominate the load-use stall, which is only meaningful in RUN.
    always_comb begin
        load_use = ix_valid && ix_memtoreg && (ix_rd != 5'd0) && id_valid &&
                   ((id_use1 && (id_rs1 == ix_rd)) || (id_use2 && (id_rs2 == ix_rd)));
        redirect_valid = (state_q == S_REDIR);
        redirect_pc    = redirect_pc_q;
        flush_if       = (state_q != S_RUN);
        flush_id       = (state_q != S_RUN);
        flush_ix       = flush_ix_q;
        busy           = (state_q != S_RUN);
        stall_id       = rst && (state_q == S_RUN) && load_use;
        br_total       = br_total_q;
        br_taken       = br_taken_q;
    end

endmodule
